// File: rtl/case_3_arith_pkg.sv
// ----------------------------------------------------------------------------
// case_3_arith_pkg
// Shared arithmetic helpers for the pipelined multiply / multiply-accumulate.
//   MAX_NUM_STAGE : deepest supported pipeline.
//   CALC_W        : working width of the helper functions. Products and
//                   results up to 64 bits are supported. The saturation
//                   range must fit in 63 bits.
//   ext_operand() : one-bit (or wider) sign / zero extension of an operand.
//   sat_add()     : signed add clamped to a dout-wide range, with flag.
// ----------------------------------------------------------------------------
package case_3_arith_pkg;

    localparam int MAX_NUM_STAGE = 8;
    localparam int CALC_W        = 64;

    // Bits [width-1:0] of raw are the operand. Every bit above them is filled
    // with the operand MSB when is_signed, otherwise with zero.
    function automatic logic signed [CALC_W-1:0] ext_operand(
        input logic [CALC_W-1:0] raw,
        input int                width,
        input logic              is_signed
    );
        logic signed [CALC_W-1:0] r;
        logic                     fill;
        fill = is_signed & raw[width-1];
        for (int i = 0; i < CALC_W; i++) begin
            r[i] = (i < width) ? raw[i] : fill;
        end
        return r;
    endfunction

    // a + b, clamped to [-2^(width-1), 2^(width-1)-1]. ovf is set when the
    // clamp was applied. The sum is formed one bit wider so it never wraps.
    function automatic logic signed [CALC_W-1:0] sat_add(
        input  logic signed [CALC_W-1:0] a,
        input  logic signed [CALC_W-1:0] b,
        input  int                       width,
        output logic                     ovf
    );
        logic signed [CALC_W:0] sum;
        logic signed [CALC_W:0] one;
        logic signed [CALC_W:0] hi;
        logic signed [CALC_W:0] lo;
        one = (CALC_W+1)'(1);
        hi  = (one <<< (width - 1)) - one;
        lo  = -hi - one;
        sum = {a[CALC_W-1], a} + {b[CALC_W-1], b};
        ovf = 1'b0;
        if (sum > hi) begin
            ovf = 1'b1;
            return CALC_W'(hi);
        end
        if (sum < lo) begin
            ovf = 1'b1;
            return CALC_W'(lo);
        end
        return CALC_W'(sum);
    endfunction

endpackage

// File: rtl/case_3_pipe_reg.sv
// ----------------------------------------------------------------------------
// case_3_pipe_reg
// WIDTH x DEPTH shift register with clock enable and synchronous reset.
//   clk   : clock, rising edge
//   reset : synchronous active-high clear of every stage
//   ce    : clock enable; 0 holds every stage
//   d     : input word
//   q     : word delayed by DEPTH enabled cycles
// DEPTH must be at least 1.
// ----------------------------------------------------------------------------
module case_3_pipe_reg #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else if (ce) begin
            stage_q[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/case_3_mul_acc_pipe.sv
// ----------------------------------------------------------------------------
// case_3_mul_acc_pipe
// Pipelined multiplier with optional saturating accumulation.
//   clk       : clock, rising edge
//   reset     : synchronous active-high; wins over ce
//   ce        : clock enable; 0 freezes every register
//   in_valid  : operands valid this cycle
//   acc_clr   : with in_valid, this token restarts the accumulator
//   din0/din1 : operands (signedness set by din0_SIGNED / din1_SIGNED)
//   out_valid : dout holds a new result
//   dout      : product (ACC_MODE=0) or accumulator (ACC_MODE=1)
//   ovf       : sticky saturation flag, accumulate mode only
// Latency is NUM_STAGE enabled cycles, throughput one token per cycle.
// ----------------------------------------------------------------------------
module case_3_mul_acc_pipe
    import case_3_arith_pkg::*;
#(
    parameter int ID          = 1,
    parameter int NUM_STAGE   = 3,
    parameter int din0_WIDTH  = 14,
    parameter int din1_WIDTH  = 12,
    parameter int dout_WIDTH  = 26,
    parameter int din0_SIGNED = 1,
    parameter int din1_SIGNED = 1,
    parameter int ACC_MODE    = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic                  acc_clr,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf
);

    localparam int STAGES = (NUM_STAGE < 1)             ? 1 :
                            (NUM_STAGE > MAX_NUM_STAGE) ? MAX_NUM_STAGE : NUM_STAGE;
    localparam int A_W    = din0_WIDTH + 1;
    localparam int B_W    = din1_WIDTH + 1;
    localparam int P_W    = A_W + B_W;

    // Stage 0: operand extension and control token
    logic signed [A_W-1:0] a_p0;
    logic signed [B_W-1:0] b_p0;
    logic [1:0]            ctl_p0;

    assign a_p0   = A_W'(ext_operand(CALC_W'(din0), din0_WIDTH, din0_SIGNED != 0));
    assign b_p0   = B_W'(ext_operand(CALC_W'(din1), din1_WIDTH, din1_SIGNED != 0));
    // acc_clr only travels with a valid token; a stray clr is dropped here.
    assign ctl_p0 = {in_valid, in_valid & acc_clr};

    // Stage 1: registered extended operands. Data registers carry no reset;
    // the valid chain alone decides whether their contents are used.
    logic signed [A_W-1:0] a_p1;
    logic signed [B_W-1:0] b_p1;

    if (STAGES >= 2) begin : g_op_reg
        logic [P_W-1:0] ops_q;
        case_3_pipe_reg #(.WIDTH(P_W), .DEPTH(1)) u_op_reg (
            .clk   (clk),
            .reset (1'b0),
            .ce    (ce),
            .d     ({a_p0, b_p0}),
            .q     (ops_q)
        );
        assign a_p1 = $signed(ops_q[P_W-1:B_W]);
        assign b_p1 = $signed(ops_q[B_W-1:0]);
    end else begin : g_op_comb
        assign a_p1 = a_p0;
        assign b_p1 = b_p0;
    end

    // Stages 2..NUM_STAGE-1: the multiply followed by a register chain that
    // retiming spreads across the multiplier array.
    logic signed [P_W-1:0] prod_p1;
    logic signed [P_W-1:0] prod_pn;

    assign prod_p1 = P_W'(a_p1) * P_W'(b_p1);

    if (STAGES >= 3) begin : g_prod_reg
        logic [P_W-1:0] prod_q;
        case_3_pipe_reg #(.WIDTH(P_W), .DEPTH(STAGES - 2)) u_prod_reg (
            .clk   (clk),
            .reset (1'b0),
            .ce    (ce),
            .d     (prod_p1),
            .q     (prod_q)
        );
        assign prod_pn = $signed(prod_q);
    end else begin : g_prod_comb
        assign prod_pn = prod_p1;
    end

    // Valid / clr chain, aligned with the data ahead of the output stage.
    logic [1:0] ctl_pn;
    logic       vld_pn;
    logic       clr_pn;

    if (STAGES >= 2) begin : g_ctl_reg
        case_3_pipe_reg #(.WIDTH(2), .DEPTH(STAGES - 1)) u_ctl_reg (
            .clk   (clk),
            .reset (reset),
            .ce    (ce),
            .d     (ctl_p0),
            .q     (ctl_pn)
        );
    end else begin : g_ctl_comb
        assign ctl_pn = ctl_p0;
    end

    assign vld_pn = ctl_pn[1];
    assign clr_pn = ctl_pn[0];

    // Output stage: dout doubles as the accumulator in accumulate mode.
    logic signed [CALC_W-1:0] acc_ext;
    logic signed [CALC_W-1:0] prod_ext;
    logic [dout_WIDTH-1:0]    dout_nxt;
    logic                     ovf_nxt;
    logic                     sat_flag;

    assign acc_ext  = CALC_W'($signed(dout));
    assign prod_ext = CALC_W'(prod_pn);

    always_comb begin
        sat_flag = 1'b0;
        dout_nxt = dout_WIDTH'(prod_pn);
        ovf_nxt  = 1'b0;
        if (ACC_MODE != 0) begin
            dout_nxt = dout_WIDTH'(sat_add(clr_pn ? '0 : acc_ext, prod_ext,
                                           dout_WIDTH, sat_flag));
            ovf_nxt  = sat_flag | (ovf & ~clr_pn);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            dout      <= '0;
            ovf       <= 1'b0;
        end else if (ce) begin
            out_valid <= vld_pn;
            if (vld_pn) begin
                dout <= dout_nxt;
                ovf  <= ovf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_case_3_mul_acc_pipe.sv
// ----------------------------------------------------------------------------
// tb_case_3_mul_acc_pipe
// Directed-vector bench for case_3_mul_acc_pipe. Five instances share one set
// of inputs:
//   u_mul : signed 14x12, 3 stages, plain multiply
//   u_mix : din0 unsigned, din1 signed, 3 stages, plain multiply
//   u_acc : signed, 26-bit accumulate
//   u_sat : signed, 16-bit accumulate (saturation cases)
//   u_s1  : single-stage plain multiply
// ----------------------------------------------------------------------------
module tb_case_3_mul_acc_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        ce;
    logic        in_valid;
    logic        acc_clr;
    logic [13:0] din0;
    logic [11:0] din1;

    logic               ov_mul, ov_mix, ov_acc, ov_sat, ov_s1;
    logic signed [25:0] do_mul, do_mix, do_acc, do_s1;
    logic signed [15:0] do_sat;
    logic               ovf_mul, ovf_mix, ovf_acc, ovf_sat, ovf_s1;

    int applied    = 0;
    int miscompares = 0;

    case_3_mul_acc_pipe #(.NUM_STAGE(3), .ACC_MODE(0)) u_mul (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .acc_clr(acc_clr),
        .din0(din0), .din1(din1), .out_valid(ov_mul), .dout(do_mul), .ovf(ovf_mul));

    case_3_mul_acc_pipe #(.NUM_STAGE(3), .din0_SIGNED(0), .din1_SIGNED(1), .ACC_MODE(0)) u_mix (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .acc_clr(acc_clr),
        .din0(din0), .din1(din1), .out_valid(ov_mix), .dout(do_mix), .ovf(ovf_mix));

    case_3_mul_acc_pipe #(.NUM_STAGE(3), .ACC_MODE(1)) u_acc (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .acc_clr(acc_clr),
        .din0(din0), .din1(din1), .out_valid(ov_acc), .dout(do_acc), .ovf(ovf_acc));

    case_3_mul_acc_pipe #(.NUM_STAGE(3), .dout_WIDTH(16), .ACC_MODE(1)) u_sat (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .acc_clr(acc_clr),
        .din0(din0), .din1(din1), .out_valid(ov_sat), .dout(do_sat), .ovf(ovf_sat));

    case_3_mul_acc_pipe #(.NUM_STAGE(1), .ACC_MODE(0)) u_s1 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .acc_clr(acc_clr),
        .din0(din0), .din1(din1), .out_valid(ov_s1), .dout(do_s1), .ovf(ovf_s1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic c, input int a, input int b);
        in_valid = v;
        acc_clr  = c;
        din0     = 14'(a);
        din1     = 12'(b);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ce    = 1'b1;
        drive(1'b0, 1'b0, 0, 0);
        tick();
        tick();
        applied++;
        if ({ov_mul, ov_mix, ov_acc, ov_sat, ov_s1} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_valid: got %b want 00000", {ov_mul, ov_mix, ov_acc, ov_sat, ov_s1});
        end
        applied++;
        if (do_mul !== 26'sd0 || do_acc !== 26'sd0 || do_sat !== 16'sd0 || do_s1 !== 26'sd0) begin
            miscompares++;
            $display("FAIL reset_dout: got %0d/%0d/%0d/%0d want 0", do_mul, do_acc, do_sat, do_s1);
        end
        applied++;
        if ({ovf_mul, ovf_acc, ovf_sat} !== 3'b0) begin
            miscompares++;
            $display("FAIL reset_ovf: got %b want 000", {ovf_mul, ovf_acc, ovf_sat});
        end
        reset = 1'b0;
        tick();
        applied++;
        if ({ov_mul, ov_s1} !== 2'b0) begin
            miscompares++;
            $display("FAIL reset_release: got %b want 00", {ov_mul, ov_s1});
        end
    endtask

    task automatic test_mode0();
        logic signed [25:0] e;
        e = 26'(-16769024);
        drive(1'b1, 1'b0, -8192, 2047);
        tick();
        drive(1'b0, 1'b0, 0, 0);
        tick();
        applied++;
        if (ov_mul !== 1'b0) begin
            miscompares++;
            $display("FAIL mode0_early: out_valid got %b want 0 at cycle 2", ov_mul);
        end
        tick();
        applied++;
        if (ov_mul !== 1'b1 || do_mul !== e) begin
            miscompares++;
            $display("FAIL mode0_result: got v=%b %0d want v=1 %0d", ov_mul, do_mul, e);
        end
        applied++;
        if (ovf_mul !== 1'b0) begin
            miscompares++;
            $display("FAIL mode0_ovf: got %b want 0", ovf_mul);
        end
        tick();
        applied++;
        if (ov_mul !== 1'b0 || do_mul !== e) begin
            miscompares++;
            $display("FAIL mode0_hold: got v=%b %0d want v=0 %0d", ov_mul, do_mul, e);
        end
    endtask

    task automatic test_back_to_back();
        int ta [4];
        int tb [4];
        int te [4];
        int j;
        ta = '{-8192, -1, 8191, -8192};
        tb = '{2047, -1, -2048, -2048};
        te = '{-16769024, 1, -16775168, 16777216};
        for (int i = 0; i < 7; i++) begin
            if (i < 4) drive(1'b1, 1'b0, ta[i], tb[i]);
            else       drive(1'b0, 1'b0, 0, 0);
            tick();
            // single-stage instance: token i appears after edge i+1
            if (i < 4) begin
                applied++;
                if (ov_s1 !== 1'b1 || do_s1 !== 26'(te[i])) begin
                    miscompares++;
                    $display("FAIL s1_token%0d: got v=%b %0d want v=1 %0d", i, ov_s1, do_s1, te[i]);
                end
            end
            // three-stage instance: token j appears after edge j+3
            j = i - 2;
            applied++;
            if (j >= 0 && j < 4) begin
                if (ov_mul !== 1'b1 || do_mul !== 26'(te[j])) begin
                    miscompares++;
                    $display("FAIL b2b_token%0d: got v=%b %0d want v=1 %0d", j, ov_mul, do_mul, te[j]);
                end
            end else if (ov_mul !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_idle%0d: out_valid got %b want 0", i, ov_mul);
            end
        end
    endtask

    task automatic test_mixed();
        drive(1'b1, 1'b0, 'h3FFF, -1);
        tick();
        drive(1'b0, 1'b0, 0, 0);
        tick();
        tick();
        applied++;
        if (ov_mix !== 1'b1 || do_mix !== 26'(-16383)) begin
            miscompares++;
            $display("FAIL mixed_sign: got v=%b %0d want v=1 -16383", ov_mix, do_mix);
        end
        applied++;
        if (do_mul !== 26'sd1) begin
            miscompares++;
            $display("FAIL mixed_signed_ref: got %0d want 1", do_mul);
        end
    endtask

    task automatic test_ce_stall();
        drive(1'b1, 1'b0, 3, 4);
        tick();
        drive(1'b1, 1'b0, 5, 6);
        tick();
        // stall with a live-looking token on the inputs: it must not enter
        ce = 1'b0;
        drive(1'b1, 1'b0, 7, 7);
        tick();
        tick();
        applied++;
        if (ov_mul !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_quiet: out_valid got %b want 0", ov_mul);
        end
        ce = 1'b1;
        drive(1'b0, 1'b0, 0, 0);
        tick();
        applied++;
        if (ov_mul !== 1'b1 || do_mul !== 26'sd12) begin
            miscompares++;
            $display("FAIL stall_first: got v=%b %0d want v=1 12", ov_mul, do_mul);
        end
        tick();
        applied++;
        if (ov_mul !== 1'b1 || do_mul !== 26'sd30) begin
            miscompares++;
            $display("FAIL stall_second: got v=%b %0d want v=1 30", ov_mul, do_mul);
        end
        tick();
        tick();
        applied++;
        if (ov_mul !== 1'b0 || do_mul !== 26'sd30) begin
            miscompares++;
            $display("FAIL stall_no_ghost: got v=%b %0d want v=0 30", ov_mul, do_mul);
        end
        // stall while a result is on the output: it is held, then not repeated
        drive(1'b1, 1'b0, 2, 9);
        tick();
        drive(1'b0, 1'b0, 0, 0);
        tick();
        tick();
        ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applied++;
            if (ov_mul !== 1'b1 || do_mul !== 26'sd18) begin
                miscompares++;
                $display("FAIL stall_hold%0d: got v=%b %0d want v=1 18", i, ov_mul, do_mul);
            end
            if (i < 2) tick();
        end
        ce = 1'b1;
        tick();
        applied++;
        if (ov_mul !== 1'b0 || do_mul !== 26'sd18) begin
            miscompares++;
            $display("FAIL stall_no_dup: got v=%b %0d want v=0 18", ov_mul, do_mul);
        end
    endtask

    task automatic test_accumulate();
        int sc [3];
        int sa [3];
        int sb [3];
        int xd [3];
        int j;
        sc = '{1, 0, 0};
        sa = '{100, 200, -3};
        sb = '{100, 50, 7};
        xd = '{10000, 20000, 19979};
        for (int i = 0; i < 5; i++) begin
            if (i < 3) drive(1'b1, sc[i][0], sa[i], sb[i]);
            else       drive(1'b0, 1'b0, 0, 0);
            tick();
            if (i >= 2) begin
                j = i - 2;
                applied++;
                if (ov_acc !== 1'b1 || do_acc !== 26'(xd[j]) || ovf_acc !== 1'b0) begin
                    miscompares++;
                    $display("FAIL acc_step%0d: got v=%b %0d ovf=%b want v=1 %0d ovf=0",
                             j, ov_acc, do_acc, ovf_acc, xd[j]);
                end
            end
        end
    endtask

    task automatic test_saturation();
        int sv [7];
        int sc [7];
        int sa [7];
        int sb [7];
        int xv [7];
        int xd [7];
        int xo [7];
        int j;
        // includes a stray clr without in_valid, which must leave ovf sticky
        sv = '{1, 1, 1, 1, 1, 0, 1};
        sc = '{1, 0, 1, 1, 0, 1, 0};
        sa = '{200, 200, 1, -200, -200, 5, 1};
        sb = '{100, 100, 1, 100, 100, 5, 1};
        xv = '{1, 1, 1, 1, 1, 0, 1};
        xd = '{20000, 32767, 1, -20000, -32768, -32768, -32767};
        xo = '{0, 1, 0, 0, 1, 1, 1};
        for (int i = 0; i < 9; i++) begin
            if (i < 7) drive(sv[i][0], sc[i][0], sa[i], sb[i]);
            else       drive(1'b0, 1'b0, 0, 0);
            tick();
            if (i >= 2) begin
                j = i - 2;
                applied++;
                if (ov_sat !== xv[j][0] || do_sat !== 16'(xd[j]) || ovf_sat !== xo[j][0]) begin
                    miscompares++;
                    $display("FAIL sat_step%0d: got v=%b %0d ovf=%b want v=%0d %0d ovf=%0d",
                             j, ov_sat, do_sat, ovf_sat, xv[j], xd[j], xo[j]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        // two tokens in flight, then a one-cycle reset with ce high
        drive(1'b1, 1'b0, 3, 4);
        tick();
        drive(1'b1, 1'b0, 5, 6);
        tick();
        drive(1'b0, 1'b0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            applied++;
            if (ov_mul !== 1'b0 || ov_sat !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_flush%0d: got v=%b/%b want 0/0", i, ov_mul, ov_sat);
            end
        end
        applied++;
        if (do_mul !== 26'sd0 || do_sat !== 16'sd0 || ovf_sat !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_state: got %0d/%0d ovf=%b want 0/0 ovf=0", do_mul, do_sat, ovf_sat);
        end
        // build saturated state, put two tokens in flight, reset with ce low
        drive(1'b1, 1'b0, 200, 100);
        tick();
        drive(1'b1, 1'b0, 200, 100);
        tick();
        drive(1'b0, 1'b0, 0, 0);
        tick();
        tick();
        applied++;
        if (ovf_sat !== 1'b1 || do_sat !== 16'sd32767) begin
            miscompares++;
            $display("FAIL rst_ce_setup: got %0d ovf=%b want 32767 ovf=1", do_sat, ovf_sat);
        end
        drive(1'b1, 1'b0, 1, 1);
        tick();
        drive(1'b1, 1'b0, 1, 1);
        tick();
        drive(1'b0, 1'b0, 0, 0);
        ce    = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        applied++;
        if (ov_sat !== 1'b0 || do_sat !== 16'sd0 || ovf_sat !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_ce_low: got v=%b %0d ovf=%b want v=0 0 ovf=0", ov_sat, do_sat, ovf_sat);
        end
        ce = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            applied++;
            if (ov_sat !== 1'b0 || do_sat !== 16'sd0 || ovf_sat !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_ce_flush%0d: got v=%b %0d ovf=%b want v=0 0 ovf=0",
                         i, ov_sat, do_sat, ovf_sat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_back_to_back();
        test_mixed();
        test_ce_stall();
        test_accumulate();
        test_saturation();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/case_3_mul_acc_pipe.md
# case_3_mul_acc_pipe

Parametrised, pipelined multiplier with optional saturating accumulation. It succeeds the single-cycle combinational multiply cores in the generated datapath. It adds:
- configurable pipeline depth and a clock enable;
- per-operand signedness and a valid token;
- an accumulate mode with sticky overflow.

It sits between operand-fetch logic and result write-back wherever a multiply or dot-product step must close timing above 300 MHz.

## Interface
Parameters:
- ID, 1, instance tag; no functional effect
- NUM_STAGE, 3, pipeline depth in cycles; legal range 1..8
- din0_WIDTH, 14, width of operand 0
- din1_WIDTH, 12, width of operand 1
- dout_WIDTH, 26, width of result and accumulator
- din0_SIGNED, 1, 1 = din0 is two's complement, 0 = unsigned
- din1_SIGNED, 1, 1 = din1 is two's complement, 0 = unsigned
- ACC_MODE, 0, 0 = plain multiply, 1 = multiply-accumulate

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous active-high reset
- ce  in  1  clock enable; 0 freezes every register
- in_valid  in  1  operands valid this cycle
- acc_clr  in  1  with in_valid: this token restarts the accumulator (ignored when ACC_MODE=0)
- din0  in  din0_WIDTH  operand 0
- din1  in  din1_WIDTH  operand 1
- out_valid  out  1  dout holds a new result
- dout  out  dout_WIDTH  product (mode 0) or accumulator (mode 1)
- ovf  out  1  sticky saturation flag (mode 1 only; constant 0 in mode 0)

## Operation
- Each operand is extended by one bit: sign-extend if SIGNED=1, zero-extend if 0.
- Full product is a signed (din0_WIDTH+1)×(din1_WIDTH+1) multiply, width P = din0_WIDTH+din1_WIDTH+2. Mixed signedness is therefore exact.
- Mode 0: dout = low dout_WIDTH bits of P when dout_WIDTH ≤ P; otherwise sign-extended. Wrap, no saturation.
- Mode 1, at the output stage when the token is valid:
  - acc_clr=1: acc = sat(product); ovf cleared, then set if this product saturated.
  - acc_clr=0: acc = sat(acc + product); ovf |= saturated.
  - sat() clamps to the signed dout_WIDTH range [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1].
- acc_clr travels down the pipe with its token and never acts out of order.
- Invalid tokens flow through but do not update dout, acc or ovf. dout holds its last value.
- No state machine beyond the valid/clr shift chain and the accumulator register.

## Timing
- Latency is exactly NUM_STAGE ce-enabled cycles from in_valid sampled high to out_valid high. Throughput is one token per cycle.
- Register placement:
  - stage 1 registers the extended operands;
  - the multiply is balanced across stages 2..NUM_STAGE-1;
  - the final stage holds dout/acc.
  - NUM_STAGE=1: one output register after the combinational multiply (and add).
- out_valid is a one-cycle pulse per token when ce is continuously high.
- ce=0: all pipeline, valid, acc and output registers hold, including out_valid and dout. Inputs are not sampled.
- Reset:
  - Values after reset: out_valid=0, dout=0, ovf=0, acc=0, all valid/clr bits 0.
  - Reset takes priority over ce; it is effective even when ce=0.
  - Tokens in flight at reset are discarded.
- acc_clr with in_valid=0 is ignored.

## Structure
- Shared package case_3_arith_pkg holds:
  - a function for saturating signed add with overflow flag;
  - an operand-extension function;
  - constant MAX_NUM_STAGE = 8.
- One sub-module, case_3_pipe_reg: a parametrised WIDTH×DEPTH shift register with ce and synchronous reset. It is used for the valid/clr chain and the product stages.

## Test plan
- Mode 0, signed 14×12, NUM_STAGE=3: din0=-8192, din1=2047 at cycle 0 → out_valid at cycle 3, dout=-16769024.
- Mixed signedness, din0_SIGNED=0, din1_SIGNED=1: din0=0x3FFF, din1=-1 → dout=-16383.
- ce stall: back-to-back tokens 3×4, 5×6. Drop ce for 2 cycles mid-flight → results 12 then 30 at cycles 5 and 6. out_valid is held, not duplicated, during the stall.
- Mode 1 accumulate: tokens (acc_clr=1, 100×100), (0, 200×50), (0, -3×7) → dout 10000, 20000, 19979; ovf=0.
- Saturation, dout_WIDTH=16, ACC_MODE=1: (clr, 200×100), (0, 200×100) → dout 20000 then 32767 with ovf=1. Next (clr, 1×1) → dout=1, ovf=0.
- Reset mid-flight: assert reset for one cycle with two tokens in the pipe → no out_valid afterwards; dout=0, ovf=0. Also assert reset while ce=0 → same result.
